// File: rtl/exp_result_buffer.sv
// Result FIFO behind the exponential core: captures {intpart, fracpart} on each rising edge of done.
// Define EXP_BUF_OVERWRITE_EN to make a push into a full FIFO replace the oldest entry instead of being dropped.
module exp_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          done,
  input  logic [1:0]    intpart,
  input  logic [15:0]   fracpart,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_int,
  output logic [15:0]   out_frac,
  output logic [CW-1:0] count,
  output logic          overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          done_q;
  logic          push, pop, full, wr_en;

  assign push = done & ~done_q;
  assign pop  = (count_q != '0) & out_ready;
  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (push && pop) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else if (push && !full) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end else if (push) begin
      ovf_d = 1'b1;
`ifdef EXP_BUF_OVERWRITE_EN
      // Full: the write lands on the oldest slot, so the head moves with it.
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      rd_ptr_d = rd_ptr_q + AW'(1);
`endif
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= done;
    end
  end

  // Array is cleared on reset so the head read is never X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= {intpart, fracpart};
    end
  end

  assign out_valid = (count_q != '0);
  assign out_int   = mem_q[rd_ptr_q][17:16];
  assign out_frac  = mem_q[rd_ptr_q][15:0];
  assign count     = count_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_exp_result_buffer.sv
// Scoreboard bench for exp_result_buffer: directed stimulus queues expected entries, a negedge monitor checks pops.
module tb_exp_result_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, clr, done, out_ready;
  logic [1:0]    intpart;
  logic [15:0]   fracpart;
  logic          out_valid, overflow;
  logic [1:0]    out_int;
  logic [15:0]   out_frac;
  logic [CW-1:0] count;

  int unsigned   total = 0;
  int unsigned   bad   = 0;
  logic [17:0]   sb [$];

  exp_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .clr(clr), .done(done),
    .intpart(intpart), .fracpart(fracpart),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_int(out_int), .out_frac(out_frac),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the next posedge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && !clr && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", {14'd0, out_int, out_frac}, 32'hFFFF_FFFF);
      end else begin
        chk("pop_data", {14'd0, out_int, out_frac}, {14'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] ip, input logic [15:0] fp);
    done = 1'b1; intpart = ip; fracpart = fp;
    tick;
    done = 1'b0;
    tick;
  endtask

  task automatic drain;
    int unsigned n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      tick;
      n++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", {31'd0, out_valid}, 32'd0);
    chk("drain_sb_empty", sb.size(), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; done = 1'b0; out_ready = 1'b0;
    intpart = '0; fracpart = '0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_data", {14'd0, out_int, out_frac}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Single result, e^1
    done = 1'b1; intpart = 2'd2; fracpart = 16'hB7E1;
    sb.push_back({2'd2, 16'hB7E1});
    tick;
    done = 1'b0;
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_int", 32'(out_int), 32'd2);
    chk("single_frac", 32'(out_frac), 32'hB7E1);
    chk("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("single_pop_count", 32'(count), 32'd0);
    chk("single_pop_valid", {31'd0, out_valid}, 32'd0);

    // Held done -> one capture
    done = 1'b1; intpart = 2'd1; fracpart = 16'h1234;
    sb.push_back({2'd1, 16'h1234});
    repeat (10) tick;
    done = 1'b0;
    tick;
    chk("held_count", 32'(count), 32'd1);
    drain;

    // Fill and overflow
    for (int i = 1; i <= 5; i++) pulse(2'd0, 16'(i));
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ovf", {31'd0, overflow}, 32'd1);
`ifdef EXP_BUF_OVERWRITE_EN
    for (int i = 2; i <= 5; i++) sb.push_back({2'd0, 16'(i)});
`else
    for (int i = 1; i <= 4; i++) sb.push_back({2'd0, 16'(i)});
`endif
    drain;
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    do_clr;
    chk("clr_ovf", {31'd0, overflow}, 32'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) pulse(2'd3, 16'(i));
    chk("full_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) sb.push_back({2'd3, 16'(i)});
    sb.push_back({2'd3, 16'd9});
    done = 1'b1; intpart = 2'd3; fracpart = 16'd9; out_ready = 1'b1;
    tick;
    done = 1'b0; out_ready = 1'b0;
    chk("pushpop_count", 32'(count), 32'd4);
    chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
    tick;
    drain;

    // clr coincident with a done edge, count=3 and overflow=1
    for (int i = 1; i <= 5; i++) pulse(2'd1, 16'(16'h100 + i));
`ifdef EXP_BUF_OVERWRITE_EN
    sb.push_back({2'd1, 16'h102});
`else
    sb.push_back({2'd1, 16'h101});
`endif
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("preclr_count", 32'(count), 32'd3);
    chk("preclr_ovf", {31'd0, overflow}, 32'd1);
    clr = 1'b1; done = 1'b1; fracpart = 16'hAAAA;
    tick;
    clr = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_ovf2", {31'd0, overflow}, 32'd0);
    chk("clr_valid", {31'd0, out_valid}, 32'd0);
    done = 1'b0;
    tick;
    chk("clr_no_late_push", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle
    pulse(2'd2, 16'h0001);
    pulse(2'd2, 16'h0002);
    chk("prerst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    chk("arst_data", {14'd0, out_int, out_frac}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    repeat (2) tick;
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/exp_result_buffer.md
# exp_result_buffer

- Downstream stage of the `exponential` core: captures each result `{intpart, fracpart}` on the rising edge of the core's `done`.
- Stores results in a small first-word-fall-through FIFO and presents them to a consumer over a valid/ready handshake.
- Decouples the core's one-shot completion from a slower consumer (display driver, serial dumper); tracks lost results with a sticky overflow flag.

## Interface
- `DEPTH`, default 4: number of FIFO entries. Power of two, ≥2.
- `CW`, default $clog2(DEPTH)+1: width of `count`. Derived; not overridden.
- `clk`  in  1: rising-edge clock, shared with `exponential`.
- `rst`  in  1: reset, asynchronous and active-low (0 = reset).
- `clr`  in  1: synchronous flush; clears contents, count and overflow.
- `done`  in  1: `exponential` done level.
- `intpart`  in  2: result integer part, valid while `done` = 1.
- `fracpart`  in  16: result fraction (unsigned Q0.16), valid while `done` = 1.
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: consumer accepts head.
- `out_int`  out  2: head integer part.
- `out_frac`  out  16: head fraction.
- `count`  out  CW: occupied entries, 0..DEPTH.
- `overflow`  out  1: sticky; a capture occurred while full.

## Operation
- Edge detect:
  - `done_d` <= `done` every cycle.
  - `push` = `done & ~done_d`.
  - A held-high `done` yields exactly one capture.
- Storage:
  - Register array, DEPTH × 18 bits: `{intpart, fracpart}`.
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is tracked explicitly.
- Pop:
  - `pop` = `out_valid & out_ready`.
  - `out_valid` = (`count` != 0).
  - `out_int`/`out_frac` = `mem[rd_ptr]`, combinational from registers. Don't-care while empty, but must not be X after reset; clear the array on reset.
- Push while not full: write `mem[wr_ptr]`, `wr_ptr`++, `count`++.
- Push + pop in the same cycle:
  - Both happen; `count` is unchanged.
  - Legal when full: the push is accepted and `overflow` is not set.
- Push while full, no pop: default behaviour is drop the new result and set `overflow`. See Configuration.
- Empty + push: `out_valid` rises the next cycle. No same-cycle bypass.
- `clr`:
  - Highest priority: zeroes pointers, `count` and `overflow`.
  - A same-cycle push or pop is discarded.
  - `done_d` still tracks `done`.
- `overflow` clears only on `rst` or `clr`.
- Reset values:
  - `out_valid` = 0, `count` = 0, `overflow` = 0.
  - `out_int` = 0, `out_frac` = 0.
  - `done_d` = 0, pointers = 0, array = 0.

## Timing
- Capture latency:
  - `done` rises before edge k; entry written at edge k.
  - `out_valid` = 1 and data visible after edge k (1 cycle).
- Pop: the head advances at the edge where `pop` = 1; the next entry is visible immediately after.
- Throughput: one push and one pop per cycle.
- `done` must stay low ≥1 cycle between results to register a new edge.
- Reset mid-operation: asynchronous; all state returns to reset values immediately and contents are lost.
- `done` high when `rst` releases: captured at the first edge (`done_d` = 0). This is intended behaviour.

## Configuration
- Macro: `EXP_BUF_OVERWRITE_EN`.
- Defined: push while full without pop overwrites the oldest entry.
  - Write at `wr_ptr`; advance both `wr_ptr` and `rd_ptr`.
  - `count` stays DEPTH; `overflow` is set.
  - The FIFO always holds the newest DEPTH results.
- Undefined (default): the new result is dropped; contents and pointers are unchanged; `overflow` is set.

## Test plan
- Single result:
  - Stimulus: reset; `done` rises with `intpart` = 2, `fracpart` = 16'hB7E1 (e^1); `out_ready` = 0.
  - Response: `out_valid` = 1 one cycle later; `out_int` = 2, `out_frac` = 16'hB7E1, `count` = 1.
  - Then `out_ready` = 1 for one cycle: `count` = 0, `out_valid` = 0.
- Held `done`: `done` held high 10 cycles with a constant value -> exactly one entry (`count` = 1).
- Fill and overflow, default build:
  - Stimulus: 5 `done` pulses with `fracpart` = 1..5; `out_ready` = 0.
  - Response: `count` = 4, `overflow` = 1; drain order 1, 2, 3, 4.
  - With `EXP_BUF_OVERWRITE_EN`: drain order 2, 3, 4, 5.
- Full with simultaneous pop:
  - Stimulus: FIFO full (1..4); a pulse with `fracpart` = 9 in the same cycle as `out_ready` = 1.
  - Response: `count` stays 4, `overflow` = 0; drain order 2, 3, 4, 9.
- `clr`: with `count` = 3, `overflow` = 1, assert `clr` coincident with a `done` edge -> next cycle `count` = 0, `overflow` = 0, `out_valid` = 0.
- Async reset: with `count` = 2, drive `rst` = 0 mid-cycle -> `out_valid`, `count` and `overflow` go to 0 before the next clock edge.
